// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline fetch/data ports, the arbiter and the memory.
// The arbiter uses the slave view; the pipeline/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          bus_err;
  logic          if_stall;
  logic          mem_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, bus_err, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, bus_err, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. Data side has priority, but a pending fetch gets the port after
// MAX_DBURST consecutive data grants. A stalled access is aborted after
// TIMEOUT not-ready cycles with a one-cycle bus_err pulse.
module mem_port_arbiter #(
  parameter int MAX_DBURST = 3,
  parameter int TIMEOUT    = 15
) (
  input logic               clk,
  input logic               clr_n,
  mem_port_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_DBURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  state_t        next_state;
  logic          grant_i;
  logic          grant_d;
  logic          done;
  logic          tmo_hit;
  logic          kill_fetch;
  logic          flushed;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] tmo_cnt;

  // The current not-ready cycle is the TIMEOUT-th one; a ready memory always wins.
  assign tmo_hit    = ~bus.mem_ready & (tmo_cnt == TMO_LAST);
  // A fetch flushed earlier in this access, or right now, must not be acknowledged.
  assign kill_fetch = flushed | bus.i_flush;
  assign bus.if_stall  = bus.i_req & ~bus.i_ack;
  assign bus.mem_stall = bus.d_req & ~bus.d_ack;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= next_state;
  end

  // Grant decision in IDLE and completion/ack generation in the BUSY states.
  always_comb begin
    next_state  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    done        = 1'b0;
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.i_rdata = '0;
    bus.d_rdata = '0;
    bus.bus_err = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && (burst_cnt < BURST_MAX || !bus.i_req)) begin
          grant_d    = 1'b1;
          next_state = BUSY_D;
        end else if (bus.i_req && !bus.i_flush) begin
          grant_i    = 1'b1;
          next_state = BUSY_I;
        end
      end
      BUSY_I: begin
        if (bus.mem_ready || tmo_hit) begin
          done        = 1'b1;
          next_state  = IDLE;
          bus.bus_err = tmo_hit;
          if (!kill_fetch) begin
            bus.i_ack = 1'b1;
            if (bus.mem_ready) bus.i_rdata = bus.mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (bus.mem_ready || tmo_hit) begin
          done        = 1'b1;
          next_state  = IDLE;
          bus.bus_err = tmo_hit;
          bus.d_ack   = 1'b1;
          if (bus.mem_ready && !bus.mem_we) bus.d_rdata = bus.mem_rdata;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory request, direction, address and write data are latched at grant time.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (grant_d) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.d_we;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
    end else if (grant_i) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.i_addr;
    end else if (done) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
    end
  end

  // Counts consecutive data grants taken while a fetch is waiting.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                 burst_cnt <= '0;
    else if (!bus.i_req || grant_i)             burst_cnt <= '0;
    else if (grant_d && burst_cnt < BURST_MAX)  burst_cnt <= burst_cnt + BW'(1);
  end

  // Counts not-ready BUSY cycles; restarts on every new grant.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                     tmo_cnt <= '0;
    else if (grant_i || grant_d)                    tmo_cnt <= '0;
    else if (state != IDLE && !bus.mem_ready && !done) tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Remembers a flush seen during the fetch so its completion is swallowed.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                     flushed <= 1'b0;
    else if (state != BUSY_I || done) flushed <= 1'b0;
    else if (bus.i_flush)           flushed <= 1'b1;
  end

endmodule
